rf_wb_arbiter: RTL and testbench

- Write-back controller for the pipelined RISC-V 32x32 register file's single write port.
- Arbitrates between the in-order pipeline WB stage (source A) and a long-latency unit such as a divider or miss-handling load (source B).
- Keeps a busy-bit scoreboard of registers owed by source B, and stalls issue on RAW/WAW hazards against it.
- Sits between the ID/issue stage, the WB stage, the long-latency unit, and the register file write port.

---
 rtl/rf_wb_if.sv | 27 ++
 rtl/rf_wb_arbiter.sv | 47 ++++
 tb/tb_rf_wb_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rf_wb_if.sv
// rf_wb_if: issue, write-back source and register-file write-port signals of the write-back arbiter.
interface rf_wb_if #(parameter int XLEN = 32);
  logic            iss_valid;
  logic            iss_long;
  logic [4:0]      iss_rd;
  logic [4:0]      iss_rs1;
  logic [4:0]      iss_rs2;
  logic            iss_stall;
  logic            a_valid;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_data;
  logic            we3;
  logic [4:0]      ra3;
  logic [XLEN-1:0] wd3;
  modport master (
    output iss_valid, iss_long, iss_rd, iss_rs1, iss_rs2, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  iss_stall, b_ready, we3, ra3, wd3
  );
  modport slave (
    input  iss_valid, iss_long, iss_rd, iss_rs1, iss_rs2, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output iss_stall, b_ready, we3, ra3, wd3
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: register-file write-port arbiter with a busy-bit scoreboard for long-latency results.
module rf_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic   clk,
  input logic   rst,
  rf_wb_if.slave bus
);
  logic [NREG-1:0] busy, busy_n;
  logic [3:0]      out_cnt, out_n;
  logic [7:0]      starve_cnt, starve_n;
  logic            grant_a, grant_b, fire, inc;
  always_comb begin
    grant_a       = !rst & bus.a_valid;
    grant_b       = !rst & bus.b_valid & !bus.a_valid;
    bus.b_ready   = grant_b;
    bus.we3       = grant_a ? bus.a_rd != '0 : grant_b & (bus.b_rd != '0);
    bus.ra3       = grant_a ? bus.a_rd : grant_b ? bus.b_rd : 5'd0;
    bus.wd3       = grant_a ? bus.a_data : grant_b ? bus.b_data : {XLEN{1'b0}};
    bus.iss_stall = rst | bus.iss_valid & (busy[bus.iss_rs1] | busy[bus.iss_rs2] | busy[bus.iss_rd]
                    | bus.iss_long & out_cnt == 4'(MAX_OUT) | starve_cnt >= 8'(STARVE_LIMIT));
    fire          = bus.iss_valid & !bus.iss_stall;
    inc           = fire & bus.iss_long;
    busy_n        = busy;
    if (grant_b) busy_n[bus.b_rd] = 1'b0;
    // set is applied after clear so it wins on a coinciding index
    if (inc) busy_n[bus.iss_rd] = 1'b1;
    busy_n[0]     = 1'b0;
    out_n         = inc & !grant_b ? out_cnt + 4'd1 :
                    grant_b & !inc & out_cnt != 4'd0 ? out_cnt - 4'd1 : out_cnt;
    starve_n      = bus.b_valid & !grant_b ? starve_cnt + {7'd0, starve_cnt != 8'hff} : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      out_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      busy       <= busy_n;
      out_cnt    <= out_n;
      starve_cnt <= starve_n;
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: scoreboard bench; a register/queue model predicts every cycle's write port and stall.
module tb_rf_wb_arbiter;
  localparam int MAX_OUT = 4;
  localparam int STARVE_LIMIT = 8;
  typedef struct {
    logic        we;
    logic [4:0]  ra;
    logic [31:0] wd;
    logic        br;
    logic        st;
  } exp_t;
  logic clk = 0;
  logic rst;
  rf_wb_if #(.XLEN(32)) bus();
  rf_wb_arbiter #(.XLEN(32), .NREG(32), .MAX_OUT(MAX_OUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  int tests = 0, fails = 0;
  bit busy[32];
  int outs = 0, starve = 0;
  int pend[$];
  bit last_gb;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("iss_stall", 32'(bus.iss_stall), 32'(e.st));
      chk("b_ready", 32'(bus.b_ready), 32'(e.br));
      chk("we3", 32'(bus.we3), 32'(e.we));
      chk("ra3", 32'(bus.ra3), 32'(e.ra));
      chk("wd3", bus.wd3, e.wd);
    end
  end
  task automatic step(input bit r, iv, il, input logic [4:0] rd, rs1, rs2,
                      input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit bv, input logic [4:0] brd, input logic [31:0] bd);
    exp_t e;
    bit ga, gb;
    rst = r; bus.iss_valid = iv; bus.iss_long = il; bus.iss_rd = rd; bus.iss_rs1 = rs1; bus.iss_rs2 = rs2;
    bus.a_valid = av; bus.a_rd = ard; bus.a_data = ad; bus.b_valid = bv; bus.b_rd = brd; bus.b_data = bd;
    ga = !r && av;
    gb = !r && bv && !av;
    e.st = r || (iv && (busy[rs1] || busy[rs2] || busy[rd] || (il && outs == MAX_OUT) || starve >= STARVE_LIMIT));
    e.br = gb;
    e.we = ga ? (ard != 0) : gb ? (brd != 0) : 1'b0;
    e.ra = ga ? ard : gb ? brd : 5'd0;
    e.wd = ga ? ad : gb ? bd : 32'd0;
    q.push_back(e);
    last_gb = gb;
    @(posedge clk);
    #1;
    if (r) begin
      foreach (busy[i]) busy[i] = 0;
      outs = 0;
      starve = 0;
    end else begin
      if (gb) begin
        if (brd != 0) busy[brd] = 0;
        if (outs > 0) outs--;
      end
      if (iv && !e.st && il) begin
        if (rd != 0) busy[rd] = 1;
        outs++;
        pend.push_back(int'(rd));
      end
      starve = (bv && !gb) ? (starve < 255 ? starve + 1 : 255) : 0;
    end
  endtask
  task automatic idle(input bit r);
    step(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    bit bvs = 0;
    logic [4:0] brs = 0;
    logic [31:0] bds = 0;
    rst = 1;
    bus.iss_valid = 0; bus.iss_long = 0; bus.iss_rd = 0; bus.iss_rs1 = 0; bus.iss_rs2 = 0;
    bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0; bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
    @(posedge clk);
    #1;
    idle(1); idle(1); idle(0);
    step(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 6, 5, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 6, 5, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
    step(0, 1, 0, 6, 5, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 8, 7, 0, 1, 3, 32'h11, 1, 7, 32'h22);
    step(0, 1, 0, 8, 7, 0, 0, 0, 0, 1, 7, 32'h22);
    step(0, 1, 0, 8, 7, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 1, 0, 9, 1, 2, 1, 5'(i + 11), 32'(i), 1, 8, 32'h88);
    step(0, 1, 0, 9, 1, 2, 0, 0, 0, 1, 8, 32'h88);
    step(0, 1, 0, 9, 1, 2, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, 1, 5'(i), 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 9, 12, 13, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1);
    step(0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'(i), 32'(i));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 32'hA);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h55);
    step(0, 1, 0, 0, 0, 0, 1, 0, 32'h66, 0, 0, 0);
    step(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 2, 32'h2, 1, 6, 32'h6);
    idle(1);
    step(0, 1, 0, 7, 5, 6, 0, 0, 0, 0, 0, 0);
    idle(1);
    pend.delete();
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 299) == 0);
      if (!bvs && pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        int k;
        k = $urandom_range(0, pend.size() - 1);
        brs = 5'(pend[k]);
        pend.delete(k);
        bds = $urandom;
        bvs = 1;
      end
      step(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), ($urandom_range(0, 9) < 4),
           5'($urandom_range(0, 7)), $urandom, bvs, brs, bds);
      if (last_gb || r) bvs = 0;
      if (r) pend.delete();
    end
    idle(0);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
